// File: rtl/joypad_pkg.sv
// Shared constants for the NES joypad port: button bit positions, per-player
// HID keymaps and the Four Score signature bytes.
package joypad_pkg;

    typedef logic [7:0] hid_code_t;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam hid_code_t HID_NONE     = 8'h00;
    localparam hid_code_t HID_ROLLOVER = 8'h01;

    localparam hid_code_t SIG_P0 = 8'h10;
    localparam hid_code_t SIG_P1 = 8'h20;

    // Row = player, column = button index (A, B, Select, Start, Up, Down, Left, Right).
    localparam hid_code_t KEYMAP [4][8] = '{
        '{8'h1B, 8'h1D, 8'h2B, 8'h28, 8'h1A, 8'h16, 8'h04, 8'h07},  // X Z Tab Enter W S A D
        '{8'h0E, 8'h0D, 8'h2D, 8'h2E, 8'h52, 8'h51, 8'h50, 8'h4F},  // K J - = arrows
        '{8'h59, 8'h5A, 8'h5B, 8'h58, 8'h60, 8'h5D, 8'h5C, 8'h5E},  // keypad cluster
        '{8'h0F, 8'h33, 8'h2F, 8'h30, 8'h18, 8'h0B, 8'h0A, 8'h11}   // L ; [ ] U H G N
    };

endpackage

// File: rtl/keycode_decoder.sv
// Maps one captured HID report onto an 8-bit NES button vector for a player,
// flags reports that must be dropped, and optionally cancels opposing directions.
module keycode_decoder
    import joypad_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int KEYS       = 6,
    parameter int SOCD_CLEAN = 1
) (
    input  logic [KEYS*8-1:0] codes,
    input  logic [1:0]        chan,
    output logic [7:0]        btn,
    output logic              discard
);

    localparam logic [2:0] N_CH_W = 3'(N_CH);

    logic [7:0] raw;
    logic       rollover;
    hid_code_t  code;

    always_comb begin
        // NOTE: every variable gets a default before the loops so no path leaves it unassigned (no latch).
        raw      = '0;
        rollover = 1'b0;
        code     = HID_NONE;
        for (int s = 0; s < KEYS; s++) begin
            code = codes[s*8 +: 8];
            if (code == HID_ROLLOVER)
                rollover = 1'b1;
            if (code != HID_NONE) begin
                for (int b = 0; b < 8; b++) begin
                    if (code == KEYMAP[chan][b])
                        raw[b] = 1'b1;
                end
            end
        end

        btn = raw;
        if (SOCD_CLEAN != 0) begin
            if (raw[BTN_UP] && raw[BTN_DOWN]) begin
                btn[BTN_UP]   = 1'b0;
                btn[BTN_DOWN] = 1'b0;
            end
            if (raw[BTN_LEFT] && raw[BTN_RIGHT]) begin
                btn[BTN_LEFT]  = 1'b0;
                btn[BTN_RIGHT] = 1'b0;
            end
        end

        discard = rollover | ({1'b0, chan} >= N_CH_W);
    end

endmodule

// File: rtl/nes_joypad_port.sv
// HID-report-to-NES controller bridge: holds per-player button states and serves
// them to the CPU through the $4016/$4017 strobe-and-shift protocol.
module nes_joypad_port
    import joypad_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int KEYS       = 6,
    parameter int FOUR_SCORE = 0,
    parameter int SOCD_CLEAN = 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              kc_valid,
    output logic              kc_ready,
    input  logic [1:0]        kc_chan,
    input  logic [KEYS*8-1:0] kc_codes,
    input  logic              cpu_strobe_we,
    input  logic              cpu_strobe_d,
    input  logic              cpu_rd,
    input  logic              cpu_rd_port,
    output logic              cpu_rd_data,
    output logic [N_CH*8-1:0] btn_state_o
);

    localparam int SR_W = (FOUR_SCORE != 0) ? 24 : 8;

    logic [KEYS*8-1:0] rpt_codes;
    logic [1:0]        rpt_chan;
    logic [7:0]        dec_btn;
    logic              dec_discard;
    logic              accept;

    logic [7:0]        btn_state [N_CH];

    logic              strobe;
    logic              strobe_next;
    logic              loaded;
    logic [SR_W-1:0]   sr0, sr1;
    logic [SR_W-1:0]   load0, load1;

    assign accept      = kc_valid & kc_ready;
    assign strobe_next = cpu_strobe_we ? cpu_strobe_d : strobe;

    keycode_decoder #(
        .N_CH       (N_CH),
        .KEYS       (KEYS),
        .SOCD_CLEAN (SOCD_CLEAN)
    ) u_decoder (
        .codes   (rpt_codes),
        .chan    (rpt_chan),
        .btn     (dec_btn),
        .discard (dec_discard)
    );

    // kc_ready low marks the one cycle in which the captured report is applied.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            kc_ready  <= 1'b1;
            rpt_codes <= '0;
            rpt_chan  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            kc_ready <= !accept;
            if (accept) begin
                rpt_codes <= kc_codes;
                rpt_chan  <= kc_chan;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            // NOTE: btn_state is a handful of flops, not a RAM, so it is cleared by reset like any register.
            for (int c = 0; c < N_CH; c++)
                btn_state[c] <= '0;
        end else if (!kc_ready && !dec_discard) begin
            for (int c = 0; c < N_CH; c++) begin
                if (rpt_chan == 2'(c))
                    btn_state[c] <= dec_btn;
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_btn_out
        assign btn_state_o[c*8 +: 8] = btn_state[c];
    end

    if (FOUR_SCORE != 0) begin : g_four_score
        if (N_CH == 4) begin : g_hi
            assign load0 = {SIG_P0, btn_state[2], btn_state[0]};
            assign load1 = {SIG_P1, btn_state[3], btn_state[1]};
        end else begin : g_no_hi
            assign load0 = {SIG_P0, 8'h00, btn_state[0]};
            assign load1 = {SIG_P1, 8'h00, btn_state[1]};
        end
    end else begin : g_standard
        assign load0 = btn_state[0];
        assign load1 = btn_state[1];
    end

    // Until the first reload the registers count as already shifted out, so reads return 1.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            strobe      <= 1'b0;
            loaded      <= 1'b0;
            sr0         <= '0;
            sr1         <= '0;
            cpu_rd_data <= 1'b0;
        end else begin
            strobe <= strobe_next;
            if (strobe_next) begin
                sr0    <= load0;
                sr1    <= load1;
                loaded <= 1'b1;
            end
            if (cpu_rd) begin
                if (strobe_next) begin
                    cpu_rd_data <= cpu_rd_port ? load1[0] : load0[0];
                end else if (!cpu_rd_port) begin
                    cpu_rd_data <= sr0[0] | !loaded;
                    sr0         <= {1'b1, sr0[SR_W-1:1]};
                end else begin
                    cpu_rd_data <= sr1[0] | !loaded;
                    sr1         <= {1'b1, sr1[SR_W-1:1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_nes_joypad_port.sv
// Directed bench: three port instances (default, raw SOCD, Four Score) share one
// stimulus stream and are checked against hand-computed values.
module tb_nes_joypad_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        kc_valid;
    logic [1:0]  kc_chan;
    logic [47:0] kc_codes;
    logic        cpu_strobe_we, cpu_strobe_d, cpu_rd, cpu_rd_port;

    logic        rdy_a, rdy_b, rdy_c;
    logic        rd_a, rd_b, rd_c;
    logic [15:0] btn_a, btn_b;
    logic [31:0] btn_c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nes_joypad_port #(.N_CH(2), .KEYS(6), .FOUR_SCORE(0), .SOCD_CLEAN(1)) dut_a (
        .clk_clk(clk), .reset_reset_n(rst_n), .kc_valid(kc_valid), .kc_ready(rdy_a),
        .kc_chan(kc_chan), .kc_codes(kc_codes), .cpu_strobe_we(cpu_strobe_we),
        .cpu_strobe_d(cpu_strobe_d), .cpu_rd(cpu_rd), .cpu_rd_port(cpu_rd_port),
        .cpu_rd_data(rd_a), .btn_state_o(btn_a));

    nes_joypad_port #(.N_CH(2), .KEYS(6), .FOUR_SCORE(0), .SOCD_CLEAN(0)) dut_b (
        .clk_clk(clk), .reset_reset_n(rst_n), .kc_valid(kc_valid), .kc_ready(rdy_b),
        .kc_chan(kc_chan), .kc_codes(kc_codes), .cpu_strobe_we(cpu_strobe_we),
        .cpu_strobe_d(cpu_strobe_d), .cpu_rd(cpu_rd), .cpu_rd_port(cpu_rd_port),
        .cpu_rd_data(rd_b), .btn_state_o(btn_b));

    nes_joypad_port #(.N_CH(4), .KEYS(6), .FOUR_SCORE(1), .SOCD_CLEAN(1)) dut_c (
        .clk_clk(clk), .reset_reset_n(rst_n), .kc_valid(kc_valid), .kc_ready(rdy_c),
        .kc_chan(kc_chan), .kc_codes(kc_codes), .cpu_strobe_we(cpu_strobe_we),
        .cpu_strobe_d(cpu_strobe_d), .cpu_rd(cpu_rd), .cpu_rd_port(cpu_rd_port),
        .cpu_rd_data(rd_c), .btn_state_o(btn_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one report; checks the hold value after the accept edge and the one-cycle ready drop.
    task automatic send_report(input logic [1:0] ch, input logic [47:0] codes,
                               input logic [15:0] hold_exp);
        int waited = 0;
        @(negedge clk);
        while (!rdy_a && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy_a) check("ready_timeout", 32'(rdy_a), 32'd1);
        kc_valid = 1'b1;
        kc_chan  = ch;
        kc_codes = codes;
        @(negedge clk);
        kc_valid = 1'b0;
        check("ready_low", 32'(rdy_a), 32'd0);
        check("btn_hold", 32'(btn_a), 32'(hold_exp));
        @(negedge clk);
        check("ready_back", 32'(rdy_a), 32'd1);
    endtask

    task automatic write_strobe(input logic d);
        @(negedge clk);
        cpu_strobe_we = 1'b1;
        cpu_strobe_d  = d;
        @(negedge clk);
        cpu_strobe_we = 1'b0;
    endtask

    task automatic read_port(input logic port, output logic a, output logic b, output logic c);
        @(negedge clk);
        cpu_rd      = 1'b1;
        cpu_rd_port = port;
        @(negedge clk);
        cpu_rd = 1'b0;
        a = rd_a;
        b = rd_b;
        c = rd_c;
    endtask

    initial begin
        logic        ra, rb, rc;
        logic [11:0] exp_rd12;
        logic [24:0] exp_fs0, exp_fs1;

        rst_n = 1'b0; kc_valid = 1'b0; kc_chan = '0; kc_codes = '0;
        cpu_strobe_we = 1'b0; cpu_strobe_d = 1'b0; cpu_rd = 1'b0; cpu_rd_port = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_btn", 32'(btn_a), 32'h0);
        check("rst_ready", 32'(rdy_a), 32'd1);
        check("rst_rd", 32'(rd_a), 32'd0);
        check("rst_btn_fs", btn_c, 32'h0);
        rst_n = 1'b1;

        // A + Start on player 0, then a full serial read past the end.
        send_report(2'd0, 48'h0000_0000_281B, 16'h0000);
        check("a_start", 32'(btn_a), 32'h0009);
        write_strobe(1'b1);
        write_strobe(1'b0);
        exp_rd12 = 12'b1111_0000_1001;
        for (int i = 0; i < 12; i++) begin
            read_port(1'b0, ra, rb, rc);
            check($sformatf("p0_read%0d", i), 32'(ra), 32'(exp_rd12[i]));
        end

        // Up + Down + Left: SOCD cancels the vertical pair only.
        send_report(2'd0, 48'h0000_0004_161A, 16'h0009);
        check("socd_clean", 32'(btn_a), 32'h0040);
        check("socd_raw", 32'(btn_b), 32'h0070);

        // ErrorRollOver leaves the state untouched.
        send_report(2'd0, 48'h0000_0000_281B, 16'h0040);
        check("restore", 32'(btn_a), 32'h0009);
        send_report(2'd0, 48'h0000_0000_0001, 16'h0009);
        check("rollover", 32'(btn_a), 32'h0009);

        // Strobe held high: reads track A without shifting.
        send_report(2'd0, 48'h0000_0000_001B, 16'h0009);
        check("a_only", 32'(btn_a), 32'h0001);
        write_strobe(1'b1);
        for (int i = 0; i < 3; i++) begin
            read_port(1'b0, ra, rb, rc);
            check($sformatf("strobe_read%0d", i), 32'(ra), 32'd1);
        end
        send_report(2'd0, 48'h0, 16'h0001);
        check("cleared", 32'(btn_a), 32'h0000);
        read_port(1'b0, ra, rb, rc);
        check("strobe_read_a0", 32'(ra), 32'd0);
        write_strobe(1'b0);

        // Four Score: player 0 A and player 2 Right.
        send_report(2'd0, 48'h0000_0000_001B, 16'h0000);
        check("fs_ch0", btn_c, 32'h0000_0001);
        send_report(2'd2, 48'h0000_0000_005E, 16'h0001);
        check("fs_ch2", btn_c, 32'h0080_0001);
        check("ch2_dropped", 32'(btn_a), 32'h0001);
        write_strobe(1'b1);
        write_strobe(1'b0);
        exp_fs0 = {1'b1, 8'h10, 8'h80, 8'h01};
        for (int i = 0; i < 25; i++) begin
            read_port(1'b0, ra, rb, rc);
            check($sformatf("fs_p0_bit%0d", i), 32'(rc), 32'(exp_fs0[i]));
        end
        write_strobe(1'b1);
        write_strobe(1'b0);
        exp_fs1 = {1'b1, 8'h20, 8'h00, 8'h00};
        for (int i = 0; i < 25; i++) begin
            read_port(1'b1, ra, rb, rc);
            check($sformatf("fs_p1_bit%0d", i), 32'(rc), 32'(exp_fs1[i]));
        end

        // Reset in the middle of a read sequence.
        write_strobe(1'b1);
        write_strobe(1'b0);
        read_port(1'b0, ra, rb, rc);
        check("pre_reset_read", 32'(ra), 32'd1);
        read_port(1'b0, ra, rb, rc);
        read_port(1'b0, ra, rb, rc);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_btn", 32'(btn_a), 32'h0);
        check("mid_rst_btn_fs", btn_c, 32'h0);
        check("mid_rst_ready", 32'(rdy_a), 32'd1);
        check("mid_rst_rd", 32'(rd_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        read_port(1'b0, ra, rb, rc);
        check("post_rst_read", 32'(ra), 32'd1);

        // Out-of-range channel completes the handshake but changes nothing.
        send_report(2'd3, 48'h0000_0000_001B, 16'h0000);
        check("chan3_dropped", 32'(btn_a), 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
